// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen
//   Takes HD/VD/DEN timing from the LCD sync generator, tracks the active-area
//   column/row and renders a selectable test pattern. The timing signals are
//   re-emitted one cycle late so they line up with the registered pixel data,
//   and every output can be wired straight to the panel.
//
// Ports
//   CLK        pixel clock (sync generator NCLK)
//   RESET      synchronous, active-high reset
//   HD, VD     horizontal / vertical sync in, active-low
//   DEN        data enable in, active-high
//   MODE       0 colour bars, 1 checkerboard, 2 grey gradient, 3 solid
//   SOLID_RGB  {R,G,B} used in MODE 3
//   HD_O/VD_O/DEN_O  timing delayed by one cycle
//   R, G, B    pixel data aligned with DEN_O, black during blanking
//   FRAME_CNT  frames started since reset, wraps 255->0
module lcd_pattern_gen #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int COLOR_W  = 8,
  parameter int CHK_LOG2 = 5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   HD,
  input  logic                   VD,
  input  logic                   DEN,
  input  logic [1:0]             MODE,
  input  logic [3*COLOR_W-1:0]   SOLID_RGB,
  output logic                   HD_O,
  output logic                   VD_O,
  output logic                   DEN_O,
  output logic [COLOR_W-1:0]     R,
  output logic [COLOR_W-1:0]     G,
  output logic [COLOR_W-1:0]     B,
  output logic [7:0]             FRAME_CNT
);

  localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int PW    = 3 * COLOR_W;

  localparam logic [XW-1:0] X_MAX   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_MAX = BW'(BAR_W - 1);

  // Colour bars: the index bits select channels so that the sequence runs
  // white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [PW-1:0] bar_px(input logic [2:0] idx);
    bar_px = {{COLOR_W{~idx[1]}}, {COLOR_W{~idx[2]}}, {COLOR_W{~idx[0]}}};
  endfunction

  function automatic logic [PW-1:0] chk_px(input logic [XW-1:0] xv,
                                           input logic [YW-1:0] yv);
    logic [XW-1:0] xs;
    logic [YW-1:0] ys;
    logic          on;
    xs = xv >> CHK_LOG2;
    ys = yv >> CHK_LOG2;
    on = |(xs & XW'(1)) ^ |(ys & YW'(1));
    chk_px = {PW{on}};
  endfunction

  // Appending COLOR_W zeros and taking the top COLOR_W bits covers both
  // cases: MSB slice of x when x is wider, left-justified x when narrower.
  function automatic logic [PW-1:0] gray_px(input logic [XW-1:0] xv);
    logic [XW+COLOR_W-1:0] ext;
    logic [COLOR_W-1:0]    g;
    ext = {xv, {COLOR_W{1'b0}}};
    g   = ext[XW+COLOR_W-1 -: COLOR_W];
    gray_px = {g, g, g};
  endfunction

  logic          vd_q, den_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] bar_cnt;
  logic [2:0]    bar_idx;
  logic [1:0]    mode_r;
  logic [7:0]    frame_cnt;

  logic          vd_fall, den_fall;
  logic [PW-1:0] pix_p0;

  logic          hd_p1, vd_p1, den_p1;
  logic [PW-1:0] rgb_p1;

  assign vd_fall  = vd_q & ~VD;
  assign den_fall = den_q & ~DEN;

  // Stage 0: position tracking and pattern selection on the incoming timing
  always_comb begin
    pix_p0 = '0;
    case (mode_r)
      2'd0:    pix_p0 = bar_px(bar_idx);
      2'd1:    pix_p0 = chk_px(x, y);
      2'd2:    pix_p0 = gray_px(x);
      default: pix_p0 = SOLID_RGB;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vd_q      <= 1'b1;
      den_q     <= 1'b0;
      x         <= '0;
      y         <= '0;
      bar_cnt   <= '0;
      bar_idx   <= '0;
      mode_r    <= '0;
      frame_cnt <= '0;
    end else begin
      vd_q  <= VD;
      den_q <= DEN;

      if (den_fall) begin
        x       <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (DEN) begin
        // Saturation makes an overlong DEN repeat the last column.
        if (x != X_MAX) x <= x + XW'(1);
        if (bar_cnt == BAR_MAX) begin
          bar_cnt <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + BW'(1);
        end
      end

      // Frame start takes priority over the line advance.
      if (vd_fall) begin
        y <= '0;
      end else if (den_fall && (y != Y_MAX)) begin
        y <= y + YW'(1);
      end

      // Mode is latched only at frame start so a frame is never mixed.
      if (vd_fall) begin
        mode_r    <= MODE;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Stage 1: output register, timing delayed to match the pixel data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hd_p1  <= 1'b1;
      vd_p1  <= 1'b1;
      den_p1 <= 1'b0;
      rgb_p1 <= '0;
    end else begin
      hd_p1  <= HD;
      vd_p1  <= VD;
      den_p1 <= DEN;
      rgb_p1 <= DEN ? pix_p0 : '0;
    end
  end

  assign HD_O      = hd_p1;
  assign VD_O      = vd_p1;
  assign DEN_O     = den_p1;
  assign R         = rgb_p1[PW-1 -: COLOR_W];
  assign G         = rgb_p1[2*COLOR_W-1 -: COLOR_W];
  assign B         = rgb_p1[COLOR_W-1:0];
  assign FRAME_CNT = frame_cnt;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
module tb_lcd_pattern_gen;

  localparam int HA = 16;
  localparam int VA = 4;
  localparam int CW = 8;
  localparam int CL = 1;

  logic        clk = 1'b0;
  logic        rst, hd, vd, den;
  logic [1:0]  mode;
  logic [23:0] solid;
  logic        hd_o, vd_o, den_o;
  logic [7:0]  r, g, b, fcnt;

  int          n_cmp = 0;
  int          n_err = 0;
  int          den_o_cnt;
  logic [23:0] cap  [0:31];
  logic [23:0] prev [0:31];
  logic [23:0] bars [0:7];
  logic [7:0]  f0;

  always #5 clk = ~clk;

  lcd_pattern_gen #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .COLOR_W (CW),
    .CHK_LOG2(CL)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .HD       (hd),
    .VD       (vd),
    .DEN      (den),
    .MODE     (mode),
    .SOLID_RGB(solid),
    .HD_O     (hd_o),
    .VD_O     (vd_o),
    .DEN_O    (den_o),
    .R        (r),
    .G        (g),
    .B        (b),
    .FRAME_CNT(fcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of timing, then sample 1 time unit after the edge.
  task automatic step(input logic h, input logic v, input logic d);
    hd  = h;
    vd  = v;
    den = d;
    @(posedge clk);
    #1;
  endtask

  task automatic vsync();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic run_line(input int n);
    den_o_cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    check("hd_o_low", 32'(hd_o), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 1'b1);
      cap[i] = {r, g, b};
      if (den_o) den_o_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (den_o) den_o_cnt++;
    end
  endtask

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

    rst = 1'b1; hd = 1'b1; vd = 1'b1; den = 1'b1; mode = 2'd0; solid = 24'h0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_rgb",   32'({r, g, b}), 32'h0);
    check("rst_den_o", 32'(den_o), 32'd0);
    check("rst_hd_o",  32'(hd_o), 32'd1);
    check("rst_vd_o",  32'(vd_o), 32'd1);
    check("rst_fcnt",  32'(fcnt), 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // Colour bars
    mode = 2'd0;
    step(1'b1, 1'b0, 1'b0);
    check("vd_o_low", 32'(vd_o), 32'd0);
    check("fcnt_1",   32'(fcnt), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    run_line(16);
    for (int i = 0; i < 16; i++) check($sformatf("bar_x%0d", i), 32'(cap[i]), 32'(bars[i/2]));
    check("bar_den_o_cnt", 32'(den_o_cnt), 32'd16);
    check("bar_blank",     32'({r, g, b}), 32'h0);

    // Grey gradient
    mode = 2'd2;
    vsync();
    check("fcnt_2", 32'(fcnt), 32'd2);
    run_line(16);
    check("grad_x12", 32'(cap[12]), 32'hC0C0C0);
    check("grad_x0",  32'(cap[0]),  32'h000000);
    check("grad_x1",  32'(cap[1]),  32'h101010);
    check("grad_x15", 32'(cap[15]), 32'hF0F0F0);
    check("grad_blank", 32'({r, g, b}), 32'h0);

    // Mode change mid-frame takes effect only at the next frame
    mode = 2'd0;
    vsync();
    run_line(16);
    check("fb_l0_x0", 32'(cap[0]), 32'hFFFFFF);
    mode = 2'd2;
    run_line(16);
    check("fb_l1_x0",  32'(cap[0]),  32'hFFFFFF);
    check("fb_l1_x4",  32'(cap[4]),  32'h00FFFF);
    check("fb_l1_x15", 32'(cap[15]), 32'h000000);
    run_line(16);
    run_line(16);
    check("fb_l3_x12", 32'(cap[12]), 32'h0000FF);
    f0 = fcnt;
    vsync();
    check("fb_fcnt_inc", 32'(fcnt), 32'(f0 + 8'd1));
    run_line(16);
    check("fb_new_x12", 32'(cap[12]), 32'hC0C0C0);

    // Checkerboard with row tracking
    mode = 2'd1;
    vsync();
    run_line(16);
    check("chk_l0_x0", 32'(cap[0]), 32'h000000);
    check("chk_l0_x1", 32'(cap[1]), 32'h000000);
    check("chk_l0_x2", 32'(cap[2]), 32'hFFFFFF);
    check("chk_l0_x3", 32'(cap[3]), 32'hFFFFFF);
    run_line(16);
    check("chk_l1_x0", 32'(cap[0]), 32'h000000);
    run_line(16);
    check("chk_l2_x0", 32'(cap[0]), 32'hFFFFFF);
    check("chk_l2_x1", 32'(cap[1]), 32'hFFFFFF);
    check("chk_l2_x2", 32'(cap[2]), 32'h000000);
    run_line(16);
    for (int i = 0; i < 16; i++) prev[i] = cap[i];
    run_line(16);
    check("chk_l4_x0", 32'(cap[0]), 32'hFFFFFF);
    for (int i = 0; i < 16; i++) check($sformatf("chk_l4_eq_l3_x%0d", i), 32'(cap[i]), 32'(prev[i]));

    // Overlong DEN in bars: x and bar index saturate
    mode = 2'd0;
    vsync();
    run_line(20);
    for (int i = 0; i < 16; i++) check($sformatf("long_bar_x%0d", i), 32'(cap[i]), 32'(bars[i/2]));
    for (int i = 16; i < 20; i++) check($sformatf("long_bar_c%0d", i + 1), 32'(cap[i]), 32'h000000);
    check("long_den_o_cnt", 32'(den_o_cnt), 32'd20);

    // Overlong DEN in gradient: last column repeats
    mode = 2'd2;
    vsync();
    run_line(20);
    for (int i = 15; i < 20; i++) check($sformatf("long_grad_c%0d", i + 1), 32'(cap[i]), 32'hF0F0F0);

    // Solid colour, channel order
    mode = 2'd3;
    solid = 24'h123456;
    vsync();
    run_line(16);
    check("solid_x3",  32'(cap[3]),  32'h123456);
    check("solid_x15", 32'(cap[15]), 32'h123456);

    // Reset in the middle of a bars line
    mode = 2'd0;
    vsync();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    check("mid_rst_rgb",   32'({r, g, b}), 32'h0);
    check("mid_rst_den_o", 32'(den_o), 32'd0);
    check("mid_rst_hd_o",  32'(hd_o), 32'd1);
    check("mid_rst_fcnt",  32'(fcnt), 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run_line(16);
    check("after_rst_x0", 32'(cap[0]), 32'hFFFFFF);
    check("after_rst_x1", 32'(cap[1]), 32'hFFFFFF);
    check("after_rst_x2", 32'(cap[2]), 32'hFFFF00);
    check("after_rst_x9", 32'(cap[9]), 32'hFF00FF);
    check("after_rst_fcnt", 32'(fcnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
